// File: rtl/ga_issue_sched.sv
// ga_issue_sched: round-robin issue scheduler sharing one GA datapath among NUM_REQ requesters,
// with in-order response routing, watchdog fault and flush. Define GA_SCHED_PERF_EN for perf counters.
module ga_issue_sched #(
   parameter int NUM_REQ     = 4,
   parameter int REQ_W       = 1100,
   parameter int RESP_W      = 512,
   parameter int MAX_OUT     = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   input  logic [NUM_REQ*REQ_W-1:0] req_data_i,
   output logic                     dp_req_valid_o,
   input  logic                     dp_req_ready_i,
   output logic [REQ_W-1:0]         dp_req_data_o,
   input  logic                     dp_resp_valid_i,
   input  logic [RESP_W-1:0]        dp_resp_data_i,
   input  logic                     dp_resp_error_i,
   output logic [NUM_REQ-1:0]       resp_valid_o,
   output logic [RESP_W-1:0]        resp_data_o,
   output logic                     resp_error_o,
   input  logic                     flush_i,
   output logic                     flush_done_o,
   output logic                     busy_o,
   output logic                     fault_o,
`ifdef GA_SCHED_PERF_EN
   output logic [31:0]              perf_issued_o,
   output logic [31:0]              perf_stall_o,
`endif
   output logic [1:0]               dbg_state_o
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             flush_done_d;
   logic [IDX_W-1:0] ptr_q, sel, head;
   logic             found;
   logic [IDX_W-1:0] id_mem [MAX_OUT];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic [WD_W-1:0]  wd_q;
   logic             any_valid, can_issue, handshake, pop, spurious, trip;

   // Handshake: a request transfers on a cycle where dp_req_valid_o and dp_req_ready_i are both high;
   // req_ready_o[sel] mirrors that transfer back to the winning requester. Responses have no backpressure.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(MAX_OUT - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   always_comb begin
      sel   = ptr_q;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found && req_valid_i[(int'(ptr_q) + k) % NUM_REQ]) begin
            sel   = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            found = 1'b1;
         end
      end
   end

   assign any_valid      = |req_valid_i;
   assign can_issue      = (state_q == ST_RUN) && !flush_i && (count_q < CNT_W'(MAX_OUT));
   assign dp_req_valid_o = can_issue && any_valid;
   assign handshake      = dp_req_valid_o && dp_req_ready_i;
   assign dp_req_data_o  = req_data_i[int'(sel)*REQ_W +: REQ_W];
   assign head           = id_mem[rd_ptr_q];
   assign pop            = dp_resp_valid_i && (count_q != '0) && (state_q != ST_FAULT);
   assign spurious       = dp_resp_valid_i && !pop;
   assign trip           = (state_q != ST_FAULT) && (count_q != '0) && !dp_resp_valid_i &&
                           (wd_q == WD_W'(TIMEOUT_CYC - 1));
   assign busy_o         = (count_q != '0) || (state_q != ST_RUN);
   assign dbg_state_o    = state_q;

   always_comb begin
      req_ready_o = '0;
      if (can_issue && dp_req_ready_i && any_valid) req_ready_o[sel] = 1'b1;
   end

   always_comb begin
      state_d      = state_q;
      flush_done_d = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (trip)         state_d = ST_FAULT;
            else if (flush_i) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (trip) state_d = ST_FAULT;
            else if (count_q == '0) begin
               state_d      = ST_RUN;
               flush_done_d = 1'b1;
            end
         end
         ST_FAULT: begin
            if (flush_i) begin
               state_d      = ST_RUN;
               flush_done_d = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_RUN;
         flush_done_o <= 1'b0;
         fault_o      <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_done_o <= flush_done_d;
         if (trip || spurious) fault_o <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (handshake) id_mem[wr_ptr_q] <= sel;
   end

   // A watchdog trip discards the outstanding IDs; any later response is then treated as spurious.
   always_ff @(posedge clk_i) begin
      if (rst_i || trip) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         wd_q     <= '0;
      end else begin
         if (handshake) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)       rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CNT_W'(handshake) - CNT_W'(pop);
         if (dp_resp_valid_i || count_q == '0) wd_q <= '0;
         else                                  wd_q <= wd_q + WD_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q        <= IDX_W'(NUM_REQ - 1);
         resp_valid_o <= '0;
         resp_data_o  <= '0;
         resp_error_o <= 1'b0;
      end else begin
         if (handshake) ptr_q <= sel;
         resp_valid_o <= '0;
         if (pop) begin
            resp_valid_o[head] <= 1'b1;
            resp_data_o        <= dp_resp_data_i;
            resp_error_o       <= dp_resp_error_i;
         end
      end
   end

`ifdef GA_SCHED_PERF_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_issued_o <= '0;
         perf_stall_o  <= '0;
      end else begin
         if (handshake)              perf_issued_o <= perf_issued_o + 32'd1;
         if (any_valid && !handshake) perf_stall_o <= perf_stall_o + 32'd1;
      end
   end
`endif

endmodule
